// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle control unit: FSM state codes, datapath
// mux selects, ALU control and data-processing opcodes.
package mc_controller_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] DP_ADD = 4'b0100;
  localparam logic [3:0] DP_SUB = 4'b0010;
  localparam logic [3:0] DP_AND = 4'b0000;
  localparam logic [3:0] DP_ORR = 4'b1100;

  // Writing R15 in writeback redirects the PC.
  function automatic logic is_pc_dest(input logic [3:0] rd);
    return rd == 4'd15;
  endfunction

endpackage

// File: rtl/mc_controller_alu_dec.sv
// Data-processing decoder: Funct[4:0] -> ALU control, legal flag and
// flag-write enables before CondEx gating. Shared with the single-cycle path.
module alu_dec
  import mc_controller_pkg::*;
(
  input  logic [4:0] i_funct,
  output logic [1:0] o_alu_control,
  output logic       o_legal,
  output logic [1:0] o_flag_w
);

  logic w_arith;

  always_comb begin
    o_alu_control = ALU_ADD;
    o_legal       = 1'b1;
    w_arith       = 1'b0;
    case (i_funct[4:1])
      DP_ADD: begin
        o_alu_control = ALU_ADD;
        w_arith       = 1'b1;
      end
      DP_SUB: begin
        o_alu_control = ALU_SUB;
        w_arith       = 1'b1;
      end
      DP_AND:  o_alu_control = ALU_AND;
      DP_ORR:  o_alu_control = ALU_ORR;
      default: o_legal       = 1'b0;
    endcase
  end

  // S bit updates NZ for every legal op; CV only for the arithmetic ones.
  assign o_flag_w[1] = i_funct[0] & o_legal;
  assign o_flag_w[0] = i_funct[0] & o_legal & w_arith;

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit: one state register sequencing FETCH/DECODE/
// execute/writeback over a shared ALU and unified memory port.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       CondEx,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagWrite,
  output logic [3:0] State
);

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic [1:0] w_dec_alu_control;
  logic       w_dec_legal;
  logic [1:0] w_dec_flag_w;
  logic       w_pc_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_mem_write;
  logic [1:0] w_flag_write;

  alu_dec u_alu_dec (
    .i_funct       (Funct[4:0]),
    .o_alu_control (w_dec_alu_control),
    .o_legal       (w_dec_legal),
    .o_flag_w      (w_dec_flag_w)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:    w_next_state = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_DP:   w_next_state = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_MEM:  w_next_state = S_MEMADR;
          OP_BR:   w_next_state = S_BRANCH;
          default: w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next_state = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next_state = MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next_state = S_FETCH;
      S_MEMWRITE: w_next_state = MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: w_next_state = S_ALUWB;
      S_EXECUTEI: w_next_state = S_ALUWB;
      S_ALUWB:    w_next_state = S_FETCH;
      S_BRANCH:   w_next_state = S_FETCH;
      default:    w_next_state = S_FETCH;
    endcase
  end

  // Datapath selects and ungated-by-reset write enables.
  always_comb begin
    AdrSrc       = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = SRCB_WD;
    ResultSrc    = RES_ALUOUT;
    ALUControl   = ALU_ADD;
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_flag_write = 2'b00;
    case (r_state)
      S_FETCH: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALU;
        w_ir_write = MemReady;
        w_pc_write = MemReady;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      S_MEMADR: begin
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
      end
      S_MEMWB: begin
        ResultSrc   = RES_DATA;
        w_reg_write = CondEx;
        w_pc_write  = CondEx & is_pc_dest(Rd);
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        w_mem_write = CondEx;
      end
      S_EXECUTER, S_EXECUTEI: begin
        ALUSrcB      = (r_state == S_EXECUTEI) ? SRCB_IMM : SRCB_WD;
        ALUControl   = w_dec_alu_control;
        w_flag_write = w_dec_flag_w & {2{CondEx}};
      end
      S_ALUWB: begin
        ResultSrc   = RES_ALUOUT;
        w_reg_write = CondEx & w_dec_legal;
        w_pc_write  = CondEx & w_dec_legal & is_pc_dest(Rd);
      end
      S_BRANCH: begin
        ALUSrcB    = SRCB_IMM;
        ResultSrc  = RES_ALU;
        w_pc_write = CondEx;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (Op)
      OP_MEM:  ImmSrc = IMM_MEM;
      OP_BR:   ImmSrc = IMM_BR;
      default: ImmSrc = IMM_DP;
    endcase
  end

  assign RegSrc = {(Op == OP_MEM) & ~Funct[0], (Op == OP_BR)};

  // Reset suppresses every architectural write, whatever the state.
  assign PCWrite   = w_pc_write  & ~reset;
  assign IRWrite   = w_ir_write  & ~reset;
  assign RegWrite  = w_reg_write & ~reset;
  assign MemWrite  = w_mem_write & ~reset;
  assign FlagWrite = w_flag_write & {2{~reset}};
  assign State     = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: a per-instruction reference model queues
// the expected per-cycle control word; a monitor compares on the falling edge.
module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       CondEx;
  logic       MemReady;
  logic       PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, FlagWrite;
  logic [3:0] State;

  mc_controller dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .CondEx(CondEx), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .FlagWrite(FlagWrite), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rst; bit cond; bit rdy;
    int st; bit st_c;
    bit pcw; bit irw; bit regw; bit memw; bit [1:0] flagw;
    bit adr; bit adr_c;
    bit srca; bit srca_c;
    bit [1:0] srcb; bit srcb_c;
    bit [1:0] res; bit res_c;
    bit [1:0] imm; bit imm_c;
    bit [1:0] rsrc; bit rsrc_c;
    bit [1:0] aluc; bit aluc_c;
  } step_t;

  step_t sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic bit rbit();
    return 1'($urandom_range(1, 0));
  endfunction

  // Expected control word for one cycle: enables default off, selects unchecked.
  function automatic step_t base(int st, bit cond, bit rdy, logic [1:0] op, logic [5:0] funct);
    step_t s;
    s = '{default: 0};
    s.st = st; s.st_c = 1'b1; s.cond = cond; s.rdy = rdy;
    if (st != 0) begin
      s.imm_c  = (op != 2'b11);
      s.imm    = op;
      s.rsrc_c = 1'b1;
      s.rsrc   = {op == 2'b01 && !funct[0], op == 2'b10};
    end
    return s;
  endfunction

  function automatic step_t sel(step_t s, bit srca, bit [1:0] srcb, bit [1:0] res);
    step_t r;
    r = s;
    r.srca = srca; r.srca_c = 1'b1;
    r.srcb = srcb; r.srcb_c = 1'b1;
    r.res  = res;  r.res_c  = 1'b1;
    return r;
  endfunction

  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct,
                           input logic [3:0] rd, input bit cond,
                           input int fw, input int mw, input int abort_at);
    step_t seq[$];
    step_t s;
    logic [1:0] ac;
    bit legal, arith, sflag;
    legal = 1'b1;
    ac = 2'b00;
    case (funct[4:1])
      4'b0100: ac = 2'b00;
      4'b0010: ac = 2'b01;
      4'b0000: ac = 2'b10;
      4'b1100: ac = 2'b11;
      default: legal = 1'b0;
    endcase
    arith = (funct[4:1] == 4'b0100) || (funct[4:1] == 4'b0010);
    sflag = funct[0];

    for (int i = 0; i <= fw; i++) begin
      s = sel(base(0, rbit(), i == fw, op, funct), 1'b1, 2'b10, 2'b10);
      s.adr_c = 1'b1; s.aluc_c = 1'b1;
      s.irw = (i == fw); s.pcw = (i == fw);
      seq.push_back(s);
    end
    seq.push_back(sel(base(1, cond, rbit(), op, funct), 1'b1, 2'b10, 2'b10));

    if (op == 2'b00) begin
      s = sel(base(funct[5] ? 7 : 6, cond, rbit(), op, funct), 1'b0,
              funct[5] ? 2'b01 : 2'b00, 2'b00);
      s.res_c = 1'b0;
      s.aluc_c = 1'b1; s.aluc = legal ? ac : 2'b00;
      s.flagw = {sflag & cond & legal, sflag & cond & legal & arith};
      seq.push_back(s);
      s = base(8, cond, rbit(), op, funct);
      s.res_c = 1'b1; s.res = 2'b00;
      s.regw = cond & legal;
      s.pcw  = cond & legal & (rd == 4'd15);
      seq.push_back(s);
    end else if (op == 2'b01) begin
      s = sel(base(2, cond, rbit(), op, funct), 1'b0, 2'b01, 2'b00);
      s.res_c = 1'b0; s.aluc_c = 1'b1;
      seq.push_back(s);
      for (int i = 0; i <= mw; i++) begin
        s = base(funct[0] ? 3 : 5, cond, i == mw, op, funct);
        s.adr_c = 1'b1; s.adr = 1'b1;
        if (funct[0]) begin s.res_c = 1'b1; s.res = 2'b00; end
        else s.memw = cond;
        seq.push_back(s);
      end
      if (funct[0]) begin
        s = base(4, cond, rbit(), op, funct);
        s.res_c = 1'b1; s.res = 2'b01;
        s.regw = cond; s.pcw = cond & (rd == 4'd15);
        seq.push_back(s);
      end
    end else if (op == 2'b10) begin
      s = sel(base(9, cond, rbit(), op, funct), 1'b0, 2'b01, 2'b10);
      s.aluc_c = 1'b1; s.pcw = cond;
      seq.push_back(s);
    end

    if (abort_at >= 0 && abort_at < seq.size()) begin
      int st_at;
      st_at = seq[abort_at].st;
      while (seq.size() > abort_at) void'(seq.pop_back());
      s = '{default: 0}; s.rst = 1'b1; s.cond = 1'b1; s.rdy = 1'b1;
      s.st = st_at; s.st_c = 1'b1;
      seq.push_back(s);
      s.st = 0;
      seq.push_back(s);
    end

    foreach (seq[i]) begin
      @(posedge clk);
      #1;
      Op = op; Funct = funct; Rd = rd;
      reset = seq[i].rst; CondEx = seq[i].cond; MemReady = seq[i].rdy;
      sb_q.push_back(seq[i]);
    end
  endtask

  step_t m_e;
  logic [21:0] m_act, m_exp, m_msk;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      m_e = sb_q.pop_front();
      m_act = {State, PCWrite, IRWrite, RegWrite, MemWrite, FlagWrite, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl};
      m_exp = {4'(m_e.st), m_e.pcw, m_e.irw, m_e.regw, m_e.memw, m_e.flagw, m_e.adr,
               m_e.srca, m_e.srcb, m_e.res, m_e.imm, m_e.rsrc, m_e.aluc};
      m_msk = {{4{m_e.st_c}}, 6'h3f, m_e.adr_c, m_e.srca_c, {2{m_e.srcb_c}},
               {2{m_e.res_c}}, {2{m_e.imm_c}}, {2{m_e.rsrc_c}}, {2{m_e.aluc_c}}};
      n_cmp++;
      if (((m_act ^ m_exp) & m_msk) != 22'd0) begin
        n_bad++;
        $display("FAIL ctrl_word t=%0t state_req=%0d: actual=%h required=%h mask=%h",
                 $time, m_e.st, m_act, m_exp, m_msk);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step_t s;
    logic [1:0] op;
    logic [5:0] funct;
    reset = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; CondEx = 1'b0; MemReady = 1'b1;

    s = '{default: 0}; s.rst = 1'b1; s.rdy = 1'b1; s.cond = 1'b1; s.st_c = 1'b1;
    @(posedge clk); #1;
    reset = s.rst; CondEx = s.cond; MemReady = s.rdy;
    sb_q.push_back(s);

    run_instr(2'b00, 6'b001001, 4'd1,  1'b1, 0, 0, -1);
    run_instr(2'b01, 6'b011001, 4'd2,  1'b1, 0, 2, -1);
    run_instr(2'b01, 6'b011000, 4'd3,  1'b0, 0, 0, -1);
    run_instr(2'b10, 6'b100000, 4'd0,  1'b1, 0, 0, -1);
    run_instr(2'b10, 6'b100000, 4'd0,  1'b0, 0, 0, -1);
    run_instr(2'b00, 6'b011000, 4'd15, 1'b1, 0, 0, -1);
    run_instr(2'b11, 6'b000000, 4'd0,  1'b1, 0, 0, -1);
    run_instr(2'b01, 6'b011000, 4'd4,  1'b1, 0, 4, 4);
    run_instr(2'b01, 6'b011001, 4'd15, 1'b1, 2, 1, -1);
    run_instr(2'b00, 6'b111111, 4'd5,  1'b1, 0, 0, -1);

    for (int n = 0; n < 80; n++) begin
      op = 2'($urandom_range(3, 0));
      funct = 6'($urandom);
      if (op == 2'b00 && $urandom_range(3, 0) != 0) begin
        case ($urandom_range(3, 0))
          0: funct[4:1] = 4'b0100;
          1: funct[4:1] = 4'b0010;
          2: funct[4:1] = 4'b0000;
          default: funct[4:1] = 4'b1100;
        endcase
      end
      run_instr(op, funct, ($urandom_range(3, 0) == 0) ? 4'd15 : 4'($urandom),
                rbit(), $urandom_range(2, 0), $urandom_range(3, 0),
                ($urandom_range(9, 0) == 0) ? $urandom_range(5, 1) : -1);
    end

    repeat (3) @(posedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: actual=%0d entries left required=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control unit for the 32-bit CPU; replaces single-cycle decode and sequencing.
- Main FSM steps each instruction through FETCH/DECODE/execute/writeback over 3-5 cycles, sharing one ALU and one unified memory port.
- Generates datapath mux selects, ALU control and CondEx-gated write enables (PC, register file, memory, flags).
- Waits on the memory handshake during every memory-access state.

Parameters:
- None (ISA subset fixed: ADD/SUB/AND/ORR reg+imm, LDR/STR imm, B).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock
- Op  in  2  Instr[27:26], from IR
- Funct  in  6  Instr[25:20], from IR
- Rd  in  4  Instr[15:12], from IR
- CondEx  in  1  condition check passed for current instruction; valid from DECODE onward
- MemReady  in  1  memory completes the access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- IRWrite  out  1  instruction register enable
- RegWrite  out  1  register file write enable
- MemWrite  out  1  data memory write strobe
- ALUSrcA  out  1  0=Rn reg A, 1=PC
- ALUSrcB  out  2  00=WriteData reg, 01=ExtImm, 10=const 4
- ResultSrc  out  2  00=ALUOut, 01=Data reg, 10=ALUResult
- ImmSrc  out  2  from Op: 00 DP, 01 mem, 10 branch
- RegSrc  out  2  as single-cycle encoding
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- FlagWrite  out  2  [1]=NZ, [0]=CV register enables
- State  out  4  current state, debug

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9. Codes 10-15 are illegal and go to FETCH next edge.
- Reset (sync): State=FETCH on the next edge. While reset is high, all enables (PCWrite, IRWrite, RegWrite, MemWrite, FlagWrite) = 0 regardless of state. Mid-instruction reset abandons the instruction with no further writes.
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=ADD.
  - Hold while MemReady=0.
  - On MemReady=1: IRWrite=1, PCWrite=1 (PC+4), ungated by CondEx; next state DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (R15 reads PC+8). Next state:
  - Op=00, Funct[5]=0 → EXECUTER
  - Op=00, Funct[5]=1 → EXECUTEI
  - Op=01 → MEMADR
  - Op=10 → BRANCH
  - Op=11 → FETCH (NOP)
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Funct[0]=1 → MEMREAD, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold until MemReady=1, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondEx, then FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=CondEx while waiting. Hold until MemReady=1, then FETCH. MemWrite stays asserted for every wait cycle.
- EXECUTER/EXECUTEI: ALUSrcA=0, ALUSrcB=00/01; ALUControl from Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
  - FlagWrite[1]=Funct[0]&CondEx.
  - FlagWrite[0]=Funct[0]&CondEx&(ADD|SUB).
  - Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=CondEx&legal, then FETCH.
- Unimplemented DP opcode ("illegal"): ALUControl=00, FlagWrite=0, RegWrite=0; instruction is a NOP.
- PC writes in writeback: Rd=15 with RegWrite also asserts PCWrite (same gating) in MEMWB/ALUWB.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx, then FETCH.
- ImmSrc/RegSrc are functions of Op only, valid from DECODE:
  - RegSrc[0]=1 for B.
  - RegSrc[1]=1 for STR.
- Outputs are combinational from State, IR fields, CondEx and MemReady (Moore, except MemReady gating in FETCH). Only State is registered.
- Latency (no wait states): B=3, DP=4, STR=4, LDR=5 cycles.

Decomposition:
- Shared package holds:
  - state enum / localparams
  - ALUSrcB, ResultSrc, ImmSrc and ALUControl encodings
  - DP opcode constants (ADD=4'b0100, SUB=4'b0010, AND=4'b0000, ORR=4'b1100)
- One sub-module, alu_dec: combinational Funct→ALUControl, legal flag and FlagW pre-gating. Reused by the existing single-cycle path.

Test Plan:
- Reset: reset high 2 cycles mid-MEMWRITE → State=0, MemWrite=0 during reset; FETCH on the first cycle after release.
- ADDS R1,R2,R3 (Op=00, Funct=001001, Rd=1), CondEx=1, MemReady=1 → states 0,1,6,8,0. FlagWrite=11 in EXECUTER; RegWrite=1 only in ALUWB.
- LDR (Op=01, Funct=011001) with MemReady low 2 cycles in MEMREAD → State=3 held 3 cycles; RegWrite=1 in MEMWB; total 7 cycles.
- STR with CondEx=0 → states 0,1,2,5,0; MemWrite=0 throughout.
- B (Op=10), CondEx=1 → PCWrite=1 in FETCH and BRANCH, ImmSrc=10. Repeated with CondEx=0 → PCWrite only in FETCH.
- ORR with Rd=15, Funct=011000 → ALUControl=11, FlagWrite=00, PCWrite=1 and RegWrite=1 in ALUWB. Op=11 → DECODE→FETCH with no writes.
